// File: rtl/shot_clock_ctrl_pkg.sv
// Shared types and constants for the shot clock controller.
//   state_t        : controller state encoding, also driven out on the state port
//   SHOT_FULL_*    : BCD digits of the 24 s reload value
//   SHOT_SHORT_*   : BCD digits of the 14 s reload value
//   bcd_dec()      : two-digit BCD decrement with tens borrow
package shot_clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        EXPIRE = 2'd3
    } state_t;

    localparam logic [3:0] SHOT_FULL_TENS  = 4'd2;
    localparam logic [3:0] SHOT_FULL_ONES  = 4'd4;
    localparam logic [3:0] SHOT_SHORT_TENS = 4'd1;
    localparam logic [3:0] SHOT_SHORT_ONES = 4'd4;
    localparam logic [3:0] BCD_NINE        = 4'd9;

    // Caller guarantees the value is above 00, so the tens borrow never underflows.
    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd0) begin
            return {tens - 4'd1, BCD_NINE};
        end
        return {tens, ones - 4'd1};
    endfunction

endpackage

// File: rtl/shot_clock_ctrl_if.sv
// Front-panel / display bundle of the shot clock controller.
//   start_n, pause_n, rst24_n, rst14_n : active-low button levels from the panel
//   bcd_tens, bcd_ones                 : countdown value to the seven-segment driver
//   running, buzzer                    : LED and buzzer drive
//   state                              : controller state (IDLE=0 RUN=1 PAUSE=2 EXPIRE=3)
// master = panel/display side, slave = controller.
interface shot_clock_ctrl_if;

    logic       start_n;
    logic       pause_n;
    logic       rst24_n;
    logic       rst14_n;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       buzzer;
    logic [1:0] state;

    modport master (
        output start_n, pause_n, rst24_n, rst14_n,
        input  bcd_tens, bcd_ones, running, buzzer, state
    );

    modport slave (
        input  start_n, pause_n, rst24_n, rst14_n,
        output bcd_tens, bcd_ones, running, buzzer, state
    );

endinterface

// File: rtl/shot_clock_ctrl_btn_edge.sv
// Button conditioner: two-flop synchroniser followed by a registered falling-edge
// detector. A press produces a single one-cycle pulse however long it is held.
//   clkout : clock
//   clr    : asynchronous active-low reset; flops return to the released level
//   btn_n  : raw active-low button level, asynchronous to clkout
//   pulse  : one-cycle press event, two edges after the first low sample
module btn_edge (
    input  logic clkout,
    input  logic clr,
    input  logic btn_n,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clkout or negedge clr) begin
        if (!clr) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= prev & ~sync2;
        end
    end

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot clock sequencer: run/pause/expire control, 1 s prescaler, BCD countdown,
// 24 s / 14 s reloads and the expiry buzzer.
//   clkout    : clock, posedge
//   clr       : asynchronous active-low reset
//   bus       : panel buttons in, BCD digits / running / buzzer / state out
// Parameters:
//   TICKS_PER_SEC : clkout cycles per displayed second (>=2)
//   BUZZ_TICKS    : clkout cycles spent in EXPIRE with the buzzer on (>=1)
//
// state  | meaning
// IDLE   | stopped, waiting for start; value shows the loaded reload
// RUN    | counting down, prescaler advancing
// PAUSE  | stopped, prescaler frozen mid-second
// EXPIRE | value 00, buzzer on for BUZZ_TICKS cycles, then reload 24 and IDLE
module shot_clock_ctrl
    import shot_clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int BUZZ_TICKS    = 200
) (
    input  logic               clkout,
    input  logic               clr,
    shot_clock_ctrl_if.slave   bus
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int BW = $clog2(BUZZ_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_TICKS - 1);

    logic ev_start;
    logic ev_pause;
    logic ev_rst24;
    logic ev_rst14;

    btn_edge u_start (.clkout(clkout), .clr(clr), .btn_n(bus.start_n), .pulse(ev_start));
    btn_edge u_pause (.clkout(clkout), .clr(clr), .btn_n(bus.pause_n), .pulse(ev_pause));
    btn_edge u_rst24 (.clkout(clkout), .clr(clr), .btn_n(bus.rst24_n), .pulse(ev_rst24));
    btn_edge u_rst14 (.clkout(clkout), .clr(clr), .btn_n(bus.rst14_n), .pulse(ev_rst14));

    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] buzz_q, buzz_d;

    logic below_short;
    logic above_one;

    assign below_short = (tens_q < SHOT_SHORT_TENS) ||
                         ((tens_q == SHOT_SHORT_TENS) && (ones_q < SHOT_SHORT_ONES));
    assign above_one   = (tens_q != 4'd0) || (ones_q > 4'd1);

    always_ff @(posedge clkout or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            tens_q  <= SHOT_FULL_TENS;
            ones_q  <= SHOT_FULL_ONES;
            presc_q <= '0;
            buzz_q  <= '0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            presc_q <= presc_d;
            buzz_q  <= buzz_d;
        end
    end

    // Reloads are checked first so they override pause, start and the second-tick.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        buzz_d  = buzz_q;
        if (ev_rst24) begin
            tens_d  = SHOT_FULL_TENS;
            ones_d  = SHOT_FULL_ONES;
            presc_d = '0;
            if (state_q == EXPIRE) state_d = IDLE;
        end else if (ev_rst14) begin
            if (below_short) begin
                tens_d = SHOT_SHORT_TENS;
                ones_d = SHOT_SHORT_ONES;
            end
            presc_d = '0;
            if (state_q == EXPIRE) state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_start) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    // Pausing on the wrap cycle leaves the prescaler at its max,
                    // so the pending tick fires on the first cycle after resume.
                    if (ev_pause) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (above_one) begin
                            {tens_d, ones_d} = bcd_dec(tens_q, ones_q);
                        end else begin
                            tens_d  = 4'd0;
                            ones_d  = 4'd0;
                            state_d = EXPIRE;
                            buzz_d  = '0;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (ev_pause || ev_start) state_d = RUN;
                end
                EXPIRE: begin
                    buzz_d = buzz_q + BW'(1);
                    if (buzz_q == BUZZ_LAST) begin
                        state_d = IDLE;
                        tens_d  = SHOT_FULL_TENS;
                        ones_d  = SHOT_FULL_ONES;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.state    = state_q;
        bus.running  = (state_q == RUN);
        bus.buzzer   = (state_q == EXPIRE);
        bus.bcd_tens = tens_q;
        bus.bcd_ones = ones_q;
    end

endmodule
